// File: rtl/arith_pkg.sv
// +----------------------------------------------------------------------------+
// | arith_pkg: op encoding, handoff state type and peer indices shared by the  |
// | arithmetic units.                                        Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam int PEER_SUB = 0;
  localparam int PEER_MUL = 1;
  localparam int PEER_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
// +----------------------------------------------------------------------------+
// | addsub_chunk: CHUNK-bit combinational adder slice; exposes the carry into  |
// | the slice MSB for signed-overflow detection.             Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module addsub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = w_full[CHUNK-1:0];
  assign cout    = w_full[CHUNK];
  // Carry into the MSB recovered from the MSB sum bit
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/chunked_addsub_unit.sv
// +----------------------------------------------------------------------------+
// | chunked_addsub_unit: multi-cycle add/sub, CHUNK bits per cycle, with       |
// | working/ack handoff to one peer. Optional macro ADDSUB_SAT_EN: saturate.   |
// |                                                          Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module chunked_addsub_unit
  import arith_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CHUNK     = 16,
  parameter int NUM_PEERS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [NUM_PEERS-1:0] dest,
  input  logic [NUM_PEERS-1:0] peer_working,
  input  logic [NUM_PEERS-1:0] peer_ack_in,
  output logic [NUM_PEERS-1:0] ack_to,
  output logic                 working,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_a, r_b, r_acc;
  logic                 r_carry;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_PEERS-1:0] r_dest;

  logic                 w_last, w_peer_busy, w_peer_ack;
  logic                 w_accept, w_calc_done, w_send_done;
  logic [CHUNK-1:0]     w_sum;
  logic                 w_cout, w_msb_cin, w_ovf;
  logic [WIDTH-1:0]     w_acc_next, w_res_final;

  // Operands shift down so the single slice always sees the current chunk
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (r_a[CHUNK-1:0]),
    .b       (r_b[CHUNK-1:0]),
    .cin     (r_carry),
    .sum     (w_sum),
    .cout    (w_cout),
    .msb_cin (w_msb_cin)
  );

  assign w_last      = (r_cnt == CNT_W'(N - 1));
  assign w_peer_busy = |(peer_working & r_dest);
  assign w_peer_ack  = |(peer_ack_in & r_dest);
  assign w_acc_next  = (r_acc >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
  assign w_ovf       = w_cout ^ w_msb_cin;

`ifdef ADDSUB_SAT_EN
  // Carry-out distinguishes negative overflow (1) from positive overflow (0)
  assign w_res_final = !w_ovf ? w_acc_next :
                       w_cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res_final = w_acc_next;
`endif

  assign working = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_calc_done  = 1'b0;
    w_send_done  = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept     = 1'b1;
        w_state_next = ST_CALC;
      end
      ST_CALC: if (w_last) begin
        w_calc_done  = 1'b1;
        w_state_next = (r_dest == '0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: if (!w_peer_busy) w_state_next = ST_SEND;
      ST_SEND: if (w_peer_ack) begin
        w_send_done  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_dest    <= '0;
      ack_to    <= '0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= (op == OP_SUB) ? ~b : b;
        r_carry <= (op == OP_SUB);
        r_dest  <= dest & (~dest + NUM_PEERS'(1));
        r_cnt   <= '0;
        r_acc   <= '0;
      end
      if (r_state == ST_CALC) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_carry <= w_cout;
        r_acc   <= w_acc_next;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_calc_done) begin
        result    <= w_res_final;
        carry_out <= w_cout;
        overflow  <= w_ovf;
        done      <= (r_dest == '0);
      end
      if ((r_state == ST_HOLD) && !w_peer_busy) ack_to <= r_dest;
      if (w_send_done) begin
        ack_to <= '0;
        done   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chunked_addsub_unit.sv
// Scoreboard bench for chunked_addsub_unit: random and directed add/sub with
// local completion and peer handoff, compared against an arithmetic model.
`default_nettype none

module tb_chunked_addsub_unit;
  import arith_pkg::*;

  localparam int WIDTH     = 64;
  localparam int CHUNK     = 16;
  localparam int NUM_PEERS = 3;
  localparam int N         = WIDTH / CHUNK;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 op_drv;
  logic [WIDTH-1:0]     a_drv, b_drv;
  logic [NUM_PEERS-1:0] dest_drv, peer_working, peer_ack_in;
  logic [NUM_PEERS-1:0] ack_to;
  logic                 working, done, carry_out, overflow;
  logic [WIDTH-1:0]     result;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  chunked_addsub_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .NUM_PEERS(NUM_PEERS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op_drv),
    .a            (a_drv),
    .b            (b_drv),
    .dest         (dest_drv),
    .peer_working (peer_working),
    .peer_ack_in  (peer_ack_in),
    .ack_to       (ack_to),
    .working      (working),
    .done         (done),
    .result       (result),
    .carry_out    (carry_out),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Exact signed/unsigned arithmetic on widened values
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic op);
    exp_t                    e;
    logic [WIDTH:0]          u;
    logic signed [WIDTH+1:0] s, smax, smin;
    smax = $signed({3'b000, {(WIDTH-1){1'b1}}});
    smin = $signed({3'b111, {(WIDTH-1){1'b0}}});
    if (op == OP_ADD) begin
      s   = $signed({{2{a[WIDTH-1]}}, a}) + $signed({{2{b[WIDTH-1]}}, b});
      u   = {1'b0, a} + {1'b0, b};
      e.c = u[WIDTH];
    end else begin
      s   = $signed({{2{a[WIDTH-1]}}, a}) - $signed({{2{b[WIDTH-1]}}, b});
      e.c = (a >= b);
    end
    e.res = s[WIDTH-1:0];
    e.v   = (s > smax) || (s < smin);
`ifdef ADDSUB_SAT_EN
    if (e.v) e.res = (s > smax) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
`endif
    return e;
  endfunction

  function automatic logic [NUM_PEERS-1:0] lowest_bit(input logic [NUM_PEERS-1:0] d);
    for (int i = 0; i < NUM_PEERS; i++)
      if (d[i]) return NUM_PEERS'(1) << i;
    return '0;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("carry_out", 64'(carry_out), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.v));
        chk("working_at_done", 64'(working), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!working) return;
    end
    chk("idle_timeout", 64'(working), 64'd0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op,
                       input logic [NUM_PEERS-1:0] dest, output int t0);
    @(negedge clk);
    start    = 1'b1;
    a_drv    = a;
    b_drv    = b;
    op_drv   = op;
    dest_drv = dest;
    sb.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic run_local(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic op, input bit busy_poke);
    int  t0;
    bit  seen;
    wait_idle();
    issue(a, b, op, '0, t0);
    chk("working_after_accept", 64'(working), 64'd1);
    if (busy_poke) begin
      @(negedge clk);
      start = 1'b1;
      a_drv = ~a;
      b_drv = a ^ 64'h1234_5678_9ABC_DEF0;
      op_drv = ~op;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) chk("done_latency", 64'(cyc - t0), 64'(N));
  endtask

  task automatic run_handoff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic op, input logic [NUM_PEERS-1:0] dest,
                             input int stall, input int ack_delay);
    int                   t0;
    bit                   quiet;
    logic [NUM_PEERS-1:0] d;
    d = lowest_bit(dest);
    wait_idle();
    peer_working = d;
    issue(a, b, op, dest, t0);
    peer_ack_in = d;
    quiet = 1;
    do begin
      @(negedge clk);
      if (ack_to != '0) quiet = 0;
    end while (cyc < t0 + N + stall);
    chk("ack_quiet_while_busy", 64'(quiet), 64'd1);
    peer_working = '0;
    peer_ack_in  = '0;
    @(negedge clk);
    chk("ack_to_rise", 64'(ack_to), 64'(d));
    for (int k = 0; k < ack_delay; k++) begin
      peer_working = '1;
      peer_ack_in  = ~d;
      @(negedge clk);
      chk("ack_to_held", 64'(ack_to), 64'(d));
    end
    peer_working = '0;
    peer_ack_in  = d;
    @(negedge clk);
    peer_ack_in = '0;
    chk("done_after_ack", 64'(done), 64'd1);
    chk("ack_to_drop", 64'(ack_to), 64'd0);
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int t0;
    logic [WIDTH-1:0]     ra, rb;
    logic [NUM_PEERS-1:0] rd;
    rst = 1'b1; start = 1'b0; op_drv = OP_ADD; a_drv = '0; b_drv = '0;
    dest_drv = '0; peer_working = '0; peer_ack_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", result, '0);
    chk("reset_flags", {58'd0, ack_to, working, done, carry_out, overflow}, '0);
    rst = 1'b0;

    run_local(64'h0000_0000_FFFF_FFFF, 64'd1, OP_ADD, 0);
    run_local(64'd5, 64'd7, OP_SUB, 0);
    run_local(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 0);
    run_local(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 0);
    run_handoff(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, OP_ADD,
                NUM_PEERS'(1) << PEER_MUL, 6, 2);
    run_local(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, OP_ADD, 1);

    // Abort an operation mid-flight; the pending expectation is discarded
    wait_idle();
    issue(64'h0123_4567_89AB_CDEF, 64'd3, OP_SUB, '0, t0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_result", result, '0);
    chk("midreset_flags", {58'd0, ack_to, working, done, carry_out, overflow}, '0);
    void'(sb.pop_back());
    run_local(64'd100, 64'd58, OP_SUB, 0);

    run_handoff(64'd9, 64'd10, OP_SUB, 3'b110, 1, 0);
    run_handoff(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, OP_ADD, 3'b101, 0, 1);
    run_handoff(64'h7FFF_0000_0000_0000, 64'h7FFF_0000_0000_0000, OP_ADD,
                NUM_PEERS'(1) << PEER_DIV, 2, 0);

    for (int i = 0; i < 40; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      rd = NUM_PEERS'($urandom_range(0, 7));
      if (rd == '0)
        run_local(ra, rb, 1'($urandom_range(0, 1)), 0);
      else
        run_handoff(ra, rb, 1'($urandom_range(0, 1)), rd,
                    $urandom_range(0, 3), $urandom_range(0, 2));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunked_addsub_unit.md
# chunked_addsub_unit

Parametrised successor to the arithmetic adder unit. It is a synthesizable, multi-cycle add/subtract engine that computes `CHUNK` bits per cycle through a registered carry chain. It forwards each result to one peer arithmetic unit (sub/mul/div class) using a `working`/`ack` handshake, and exposes local completion when no peer is addressed.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width; must be a multiple of `CHUNK`
- `CHUNK`, 16, bits computed per cycle; N = WIDTH/CHUNK compute cycles
- `NUM_PEERS`, 3, number of peer units reachable by handoff

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  operation request, sampled only in IDLE
- `op`  in  1  0 = add, 1 = subtract (a − b)
- `a`, `b`  in  WIDTH  operands, captured when start is accepted
- `dest`  in  NUM_PEERS  one-hot destination peer; all-zero = local only
- `peer_working`  in  NUM_PEERS  peer busy flags
- `peer_ack_in`  in  NUM_PEERS  peer accepted the handed-off result
- `ack_to`  out  NUM_PEERS  result-valid toward the addressed peer
- `working`  out  1  high from the cycle after accept until return to IDLE
- `done`  out  1  one-cycle pulse on completion (local or handoff)
- `result`  out  WIDTH  registered result, held until the next accept
- `carry_out`  out  1  unsigned carry (add) / not-borrow (sub)
- `overflow`  out  1  signed overflow

## Operation
- States: IDLE, CALC, HOLD, SEND.
- IDLE: when `start`=1, capture `a`, `b`, `op`, `dest`, then go to CALC. Subtraction is performed as a + ~b with carry-in 1.
- Multi-bit `dest`: only the lowest set bit is kept at capture.
- CALC: one `CHUNK` slice per cycle, least-significant first. Carry is registered between slices. After slice N−1, write `result`, `carry_out`, and `overflow`.
  - If `dest`==0: go to IDLE and pulse `done`.
  - Otherwise go to HOLD.
- HOLD: wait while `peer_working[d]`=1. When it is 0, go to SEND.
- SEND: assert `ack_to[d]` and hold it high until `peer_ack_in[d]`=1 is sampled. Then deassert it, pulse `done`, and go to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- A `peer_ack_in` on a non-addressed bit, or outside SEND, is ignored.
- `peer_working[d]` rising during SEND does not revoke `ack_to`.

## Timing
- Reset: state IDLE; `ack_to`, `working`, `done`, `result`, `carry_out`, `overflow` all 0. The carry register and captured operands are also cleared.
- Reset mid-operation: the operation is discarded and outputs return to reset values the next cycle.
- Accept at edge T0. `working`=1 from T0+1. Slices complete at T0+1 … T0+N. `result` is valid at T0+N+1.
- Local completion: `done`=1 and `working`=0 in cycle T0+N+1.
- Handoff with idle peer: `ack_to[d]`=1 from T0+N+2. If `peer_ack_in[d]` is high in the same cycle, `done` pulses and `ack_to` and `working` drop one cycle later.
- A new `start` is accepted in the first IDLE cycle (the cycle in which `working`=0).

## Configuration
- `ADDSUB_SAT_EN` defined: on signed overflow, `result` clamps to the most-positive value 0x7FF…F (positive overflow) or the most-negative value 0x800…0 (negative overflow). `overflow` is still reported.
- `ADDSUB_SAT_EN` undefined: two's-complement wraparound; `overflow` is flag only.

## Structure
- Shared package `arith_pkg`: op encoding (`OP_ADD`, `OP_SUB`), state enum, and peer index constants (`PEER_SUB`, `PEER_MUL`, `PEER_DIV`).
- Sub-module `addsub_chunk`: `CHUNK`-bit combinational slice taking a, b, cin and producing sum, cout, and the MSB carry-in for the overflow calculation. Instantiated once and time-multiplexed across slices.

## Test plan
- Add, `dest`=0: a=0x0000_0000_FFFF_FFFF, b=1 → result=0x0000_0001_0000_0000, carry_out=0, `done` at T0+5 (WIDTH=64, CHUNK=16).
- Sub with borrow: a=5, b=7 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → overflow=1. Result is 0x8000_0000_0000_0000 without `ADDSUB_SAT_EN`, and 0x7FFF_FFFF_FFFF_FFFF with it.
- Handoff stall: `dest`=3'b010 with `peer_working[1]`=1 for 6 cycles → `ack_to` stays 0 during the stall and rises the cycle after `peer_working[1]` falls. It is held until `peer_ack_in[1]`, then `done` pulses.
- Busy rejection: a second `start` during CALC with different operands → ignored; the first result is unchanged.
- Mid-operation reset: `rst` at T0+2 → all outputs 0 at T0+3. A fresh `start` in the next cycle completes normally.
